// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-word pipeline: control-word field layout,
// the NOP/bubble constant and a constant-evaluable clog2.
package ctrl_pipe_pkg;

  // Control-word layout, LSB first; each offset chains off the previous field
  localparam int unsigned SHIFT_IMM_OFF = 0;
  localparam int unsigned SHIFT_IMM_W   = 5;
  localparam int unsigned ALU_OP_OFF    = SHIFT_IMM_OFF + SHIFT_IMM_W;
  localparam int unsigned ALU_OP_W      = 4;
  localparam int unsigned MEM_SIZE_OFF  = ALU_OP_OFF + ALU_OP_W;
  localparam int unsigned MEM_SIZE_W    = 2;
  localparam int unsigned MEM_EN_BIT    = MEM_SIZE_OFF + MEM_SIZE_W;
  localparam int unsigned RW_BIT        = MEM_EN_BIT + 1;
  localparam int unsigned LOAD_BIT      = RW_BIT + 1;
  localparam int unsigned S_BIT         = LOAD_BIT + 1;
  localparam int unsigned RF_EN_BIT     = S_BIT + 1;
  localparam int unsigned CTRL_W        = RF_EN_BIT + 1;

  // All-zero control word disables every side effect
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = 32'(i + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_pipe_stage.sv
// One pipeline stage: a valid bit plus control word, with flush > hold > bubble > load priority.
module pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = CTRL_W,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(CTRL_NOP)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             bubble_i,
  input  logic [WIDTH-1:0] d_word_i,
  input  logic             d_valid_i,
  output logic [WIDTH-1:0] q_word_o,
  output logic             q_valid_o
);

  logic [WIDTH:0] stage_q;
  logic [WIDTH:0] stage_d;

  always_comb begin
    stage_d = {d_valid_i, d_word_i};
    if (flush_i) begin
      stage_d = {1'b0, BUBBLE};
    end else if (hold_i) begin
      stage_d = stage_q;
    end else if (bubble_i) begin
      stage_d = {1'b0, BUBBLE};
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      stage_q <= {1'b0, BUBBLE};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_word_o  = stage_q[WIDTH-1:0];
  assign q_valid_o = stage_q[WIDTH];

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Uniform control-word pipeline after ID: per-stage valid, stall with bubble
// insertion below the hold boundary, per-stage flush, occupancy and perf counters.
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = CTRL_W,
  parameter int unsigned      DEPTH  = 3,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(CTRL_NOP),
  parameter int unsigned      CNT_W  = 16
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic [WIDTH-1:0]              in_word,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DEPTH-1:0]              stall,
  input  logic [DEPTH-1:0]              flush,
  output logic [DEPTH*WIDTH-1:0]        stage_word,
  output logic [DEPTH-1:0]              stage_valid,
  output logic [clog2(DEPTH+1)-1:0]     occupancy,
  output logic [CNT_W-1:0]              bubble_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  localparam int unsigned      OCC_W   = clog2(DEPTH + 1);
  localparam int unsigned      SUM_W   = CNT_W + OCC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] hold_c;
  logic [DEPTH-1:0] bubble_c;
  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [OCC_W-1:0] occ_c;
  logic [OCC_W-1:0] flush_inc_c;
  logic [SUM_W-1:0] flush_sum_c;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Hold boundary: stage i holds when any stall at or above it is set;
  // the stage just past the boundary takes the bubble.
  always_comb begin
    hold_c   = '0;
    bubble_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hold_c[i] = |(stall >> i);
    end
    for (int i = 1; i < DEPTH; i++) begin
      bubble_c[i] = stall[i-1] & ~hold_c[i];
    end
  end

  assign in_ready = ~|stall;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] d_word;
    logic             d_valid;

    if (g == 0) begin : g_head
      assign d_word  = in_valid ? in_word : BUBBLE;
      assign d_valid = in_valid;
    end else begin : g_body
      assign d_word  = word_q[g-1];
      assign d_valid = valid_q[g-1];
    end

    pipe_stage #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
    ) u_stage (
      .CLK       (CLK),
      .CLR       (CLR),
      .flush_i   (flush[g]),
      .hold_i    (hold_c[g]),
      .bubble_i  (bubble_c[g]),
      .d_word_i  (d_word),
      .d_valid_i (d_valid),
      .q_word_o  (word_q[g]),
      .q_valid_o (valid_q[g])
    );

    assign stage_word[g*WIDTH +: WIDTH] = word_q[g];
  end

  assign stage_valid = valid_q;

  // Occupancy and the number of live entries killed by flush this edge
  always_comb begin
    occ_c       = '0;
    flush_inc_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_c       = occ_c + OCC_W'(valid_q[i]);
      flush_inc_c = flush_inc_c + OCC_W'(valid_q[i] & flush[i]);
    end
  end

  assign occupancy = occ_c;

  // Saturating counters; a flushed bubble target is not a stall-induced bubble
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (|(bubble_c & ~flush) && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    flush_sum_c = SUM_W'(flush_cnt_q) + SUM_W'(flush_inc_c);
    flush_cnt_d = (flush_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(flush_sum_c);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain: directed scenarios plus randomized
// stall/flush traffic against a behavioural model of the pipeline rules.
module tb_ctrl_pipe_chain;

  localparam int unsigned W       = 8;
  localparam int unsigned D       = 3;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic           CLK = 1'b0;
  logic           CLR;
  logic [W-1:0]   in_word;
  logic           in_valid;
  logic           in_ready;
  logic [D-1:0]   stall;
  logic [D-1:0]   flush;
  logic [D*W-1:0] stage_word;
  logic [D-1:0]   stage_valid;
  logic [1:0]     occupancy;
  logic [CW-1:0]  bubble_cnt;
  logic [CW-1:0]  flush_cnt;

  ctrl_pipe_chain #(
    .WIDTH  (W),
    .DEPTH  (D),
    .BUBBLE (8'h00),
    .CNT_W  (CW)
  ) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .in_word     (in_word),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .stage_word  (stage_word),
    .stage_valid (stage_valid),
    .occupancy   (occupancy),
    .bubble_cnt  (bubble_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [D*W-1:0] word;
    logic [D-1:0]   valid;
    int             occ;
    int             bc;
    int             fc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] m_word  [D];
  logic         m_valid [D];
  int           m_bc;
  int           m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_word[i]  = '0;
      m_valid[i] = 1'b0;
    end
    m_bc = 0;
    m_fc = 0;
  endtask

  // Next state straight from the pipeline rules: flush > hold > bubble > shift
  task automatic model_step(input logic [W-1:0] w, input logic v,
                            input logic [D-1:0] s, input logic [D-1:0] f);
    logic [W-1:0] nw [D];
    logic         nv [D];
    int h = -1;
    int killed = 0;
    for (int i = 0; i < D; i++) if (s[i]) h = i;
    for (int i = 0; i < D; i++) begin
      if (f[i]) begin
        nw[i] = '0; nv[i] = 1'b0;
      end else if (i <= h) begin
        nw[i] = m_word[i]; nv[i] = m_valid[i];
      end else if (h >= 0 && i == h + 1) begin
        nw[i] = '0; nv[i] = 1'b0;
      end else if (i == 0) begin
        nw[i] = v ? w : '0; nv[i] = v;
      end else begin
        nw[i] = m_word[i-1]; nv[i] = m_valid[i-1];
      end
    end
    if (h >= 0 && h < D - 1 && !f[h+1]) m_bc = (m_bc >= CNT_MAX) ? CNT_MAX : m_bc + 1;
    for (int i = 0; i < D; i++) if (f[i] && m_valid[i]) killed++;
    m_fc = (m_fc + killed > CNT_MAX) ? CNT_MAX : m_fc + killed;
    for (int i = 0; i < D; i++) begin
      m_word[i]  = nw[i];
      m_valid[i] = nv[i];
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.word  = '0;
    e.valid = '0;
    e.occ   = 0;
    for (int i = 0; i < D; i++) begin
      e.word[i*W +: W] = m_word[i];
      e.valid[i]       = m_valid[i];
      if (m_valid[i]) e.occ++;
    end
    e.bc = m_bc;
    e.fc = m_fc;
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs; the expected post-edge state goes to the scoreboard
  task automatic step(input logic [W-1:0] w, input logic v,
                      input logic [D-1:0] s, input logic [D-1:0] f);
    @(negedge CLK);
    in_word  = w;
    in_valid = v;
    stall    = s;
    flush    = f;
    #1;
    chk("in_ready", 32'(in_ready), 32'(~|s));
    model_step(w, v, s, f);
    push_exp();
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: outputs are presented every edge; compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stage_word", 32'(stage_word), 32'(e.word));
        chk("stage_valid", 32'(stage_valid), 32'(e.valid));
        chk("occupancy", 32'(occupancy), 32'(e.occ));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(e.bc));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic         v;
    logic [D-1:0] s;
    logic [D-1:0] f;
    logic         prev_ready;

    CLR = 1'b1; in_word = '0; in_valid = 1'b0; stall = '0; flush = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_word", 32'(stage_word), 32'h0);
    chk("rst_valid", 32'(stage_valid), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_bcnt", 32'(bubble_cnt), 32'h0);
    chk("rst_fcnt", 32'(flush_cnt), 32'h0);
    CLR = 1'b0;

    // Streaming fill
    step(8'h11, 1'b1, 3'b000, 3'b000);
    step(8'h22, 1'b1, 3'b000, 3'b000);
    step(8'h33, 1'b1, 3'b000, 3'b000);
    settle();
    chk("stream_word", 32'(stage_word), 32'h112233);
    chk("stream_occ", 32'(occupancy), 32'd3);

    // Stall stage 1 twice with a full chain
    step(8'h44, 1'b1, 3'b010, 3'b000);
    step(8'h44, 1'b1, 3'b010, 3'b000);
    settle();
    chk("stall_word", 32'(stage_word), 32'h002233);
    chk("stall_valid", 32'(stage_valid), 32'b011);
    chk("stall_bcnt", 32'(bubble_cnt), 32'd2);

    // Refill, then flush stages 0 and 1
    step(8'h44, 1'b1, 3'b000, 3'b000);
    step(8'h55, 1'b1, 3'b000, 3'b000);
    step(8'h66, 1'b1, 3'b000, 3'b011);
    settle();
    chk("flush_word", 32'(stage_word), 32'h440000);
    chk("flush_fcnt", 32'(flush_cnt), 32'd2);

    // Full freeze leaves everything untouched
    step(8'h77, 1'b1, 3'b000, 3'b000);
    repeat (3) step(8'h88, 1'b1, 3'b100, 3'b000);
    settle();
    chk("freeze_word", 32'(stage_word), 32'h000077);
    chk("freeze_bcnt", 32'(bubble_cnt), 32'd2);

    // Saturation of the bubble counter
    repeat (20) step(8'h99, 1'b1, 3'b001, 3'b000);
    settle();
    chk("sat_bcnt", 32'(bubble_cnt), 32'd15);

    // Asynchronous CLR with all stages valid
    repeat (3) step(8'hA1, 1'b1, 3'b000, 3'b000);
    @(negedge CLK);
    #2;
    CLR = 1'b1;
    #1;
    chk("clr_word", 32'(stage_word), 32'h0);
    chk("clr_valid", 32'(stage_valid), 32'h0);
    chk("clr_occ", 32'(occupancy), 32'h0);
    chk("clr_bcnt", 32'(bubble_cnt), 32'h0);
    chk("clr_fcnt", 32'(flush_cnt), 32'h0);
    model_reset();
    settle();
    chk("clr_hold_valid", 32'(stage_valid), 32'h0);
    CLR = 1'b0;

    // Flush and stall together on stage 1
    step(8'hB1, 1'b1, 3'b000, 3'b000);
    step(8'hB2, 1'b1, 3'b000, 3'b000);
    step(8'hB3, 1'b1, 3'b000, 3'b000);
    step(8'hB4, 1'b1, 3'b010, 3'b010);
    settle();
    chk("fs_word", 32'(stage_word), 32'h0000B3);
    chk("fs_valid", 32'(stage_valid), 32'b001);
    chk("fs_bcnt", 32'(bubble_cnt), 32'd1);
    chk("fs_fcnt", 32'(flush_cnt), 32'd1);

    // Randomized traffic; the source holds its word while not ready
    w = '0; v = 1'b0; prev_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (prev_ready) begin
        w = W'($urandom);
        v = ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < D; i++) begin
        s[i] = ($urandom_range(0, 5) == 0);
        f[i] = ($urandom_range(0, 7) == 0);
      end
      step(w, v, s, f);
      prev_ready = ~|s;
    end
    settle();
    @(negedge CLK);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised control-word pipeline carrying decoded control bits from the ID mux through DEPTH downstream stages (EX, MEM, WB, …). It replaces the fixed IDEX/EXMEM/MEMWB control registers with one uniform chain. It adds a per-stage valid bit, stall with automatic bubble insertion, per-stage flush, an occupancy output and saturating performance counters.

## Interface
- WIDTH, 16: bits per control word.
- DEPTH, 3: number of stages, ≥2; stage 0 is the first stage after ID.
- BUBBLE, 0: word loaded into a stage when it becomes empty; all-zero is NOP.
- CNT_W, 16: width of each performance counter.
- CLK  in  1  clock; all state updates on posedge.
- CLR  in  1  reset, asynchronous, active-high.
- in_word  in  WIDTH  control word from the ID-stage mux.
- in_valid  in  1  in_word holds a real instruction.
- in_ready  out  1  stage 0 accepts in_word this cycle; combinational, equal to ~|stall.
- stall  in  DEPTH  stall[i]: stage i must hold its contents.
- flush  in  DEPTH  flush[i]: stage i becomes a bubble at the next edge.
- stage_word  out  DEPTH*WIDTH  registered word of stage i at bits [i*WIDTH +: WIDTH].
- stage_valid  out  DEPTH  registered valid bit per stage.
- occupancy  out  clog2(DEPTH+1)  popcount of stage_valid; combinational from registers.
- bubble_cnt  out  CNT_W  stall-induced bubble insertions; saturating.
- flush_cnt  out  CNT_W  valid entries destroyed by flush; saturating.

## Operation
- Hold boundary h is the highest index i with stall[i]=1. When no stall bit is set, h does not exist.
- Each stage's next state is chosen in this priority order: CLR > flush > hold > bubble > shift.
  - CLR: every word is BUBBLE, every valid is 0, both counters are 0. Applies asynchronously, mid-operation included; the values persist until the first edge after CLR deasserts.
  - flush[i]: word_i gets BUBBLE and valid_i gets 0. This holds even if stage i is inside the hold region.
  - hold (i ≤ h): word_i and valid_i keep their values.
  - bubble (i = h+1, and h+1 < DEPTH): stage i loads BUBBLE with valid 0.
  - shift (i > h+1, or no stall): stage 0 loads in_valid ? in_word : BUBBLE, with valid = in_valid. Stage i>0 loads the previous contents of stage i-1.
- An invalid stage always carries BUBBLE. Downstream logic may use the word directly without gating.
- If stall[DEPTH-1]=1, the whole chain freezes and no bubble is inserted.
- Input handshake: a word is consumed only on an edge where in_ready=1. When in_ready=0, the source holds in_word/in_valid, and the chain ignores them.
- bubble_cnt increments by 1 on each edge where h exists, h < DEPTH-1, and flush[h+1]=0.
- flush_cnt increments on each edge by the number of stages with flush[i]=1 and valid_i=1.
- Both counters saturate at 2^CNT_W-1. A saturated counter holds and does not wrap.
- Simultaneous flush and stall on the same stage: that stage becomes a bubble and is still treated as held, so the stage above it does not move into it.

## Timing
- Latency: a word accepted at edge n appears in stage i after edge n+i, i.e. i+1 cycles of visibility delay, when there are no stalls.
- Each cycle of stall at h delays stage h and every earlier stage by exactly one cycle.
- in_ready and occupancy are combinational. All other outputs are registered with no combinational input-to-output path.
- Reset values: stage_word = BUBBLE repeated, stage_valid = 0, occupancy = 0, bubble_cnt = 0, flush_cnt = 0. in_ready follows stall even during CLR.

## Structure
- Shared package ctrl_pipe_pkg holds:
  - the default BUBBLE/NOP constant;
  - the control-word field offsets: shift_imm, ALU op, mem size, mem enable, R/W, load, S, RF enable;
  - a clog2 helper.
- Sub-module pipe_stage holds one WIDTH+1-bit register with async CLR and per-stage controls flush, hold, bubble, and d-in. It is instantiated DEPTH times in a generate loop.
- ctrl_pipe_chain contains:
  - the hold-boundary priority encoder;
  - the per-stage control decode;
  - the occupancy popcount;
  - the two saturating counters.

## Test plan
Bench parameters: WIDTH=8, DEPTH=3, CNT_W=4.
- Reset: assert CLR mid-stream with all stages valid -> outputs go immediately (before the next edge) to words 0x00, valid 000, counters 0.
- Streaming: in_word 0x11, 0x22, 0x33 on consecutive edges with valid=1 -> after the 3rd edge, stage_word = {0x11,0x22,0x33} for stages 2,1,0, occupancy 3.
- Stall stage 1 for 2 cycles with a full chain:
  - stages 0 and 1 hold;
  - stage 2 shows a bubble (valid 0, 0x00) after the first of those edges;
  - bubble_cnt = 2;
  - in_ready = 0 throughout.
- Flush stages 0 and 1 while both are valid -> both become 0x00/invalid, flush_cnt += 2, and stage 2 shifts normally.
- Full freeze and saturation:
  - stall[2]=1 -> no stage changes and bubble_cnt is unchanged;
  - then 20 consecutive stall[0] cycles -> bubble_cnt saturates at 15.
- Flush and stall on stage 1 at the same edge -> stage 1 becomes a bubble, stage 0 holds, and stage 2 receives nothing new (a bubble from the stage-1 hold boundary). bubble_cnt += 1 and flush_cnt += 1.
